conv_window_feeder: RTL and testbench
=====================================

# conv_window_feeder

Streaming 3x3 window generator that drives the convolver MAC's nine line operands (`input_line_1..9`) and its `enable`. It accepts a raster-order pixel stream for one feature-map frame and buffers the two previous rows in internal line buffers. For every pixel position with a full 3x3 neighbourhood (valid convolution, no padding), it presents one registered window plus a window-valid strobe. It sits between the activation fetch path and the `mac` instances.

## Interface
Parameters:
- `WID_LINE`, 16: pixel/window element width (matches MAC line width).
- `MAX_COLS`, 256: maximum frame width; depth of each line buffer.
- `COL_W`, `$clog2(MAX_COLS+1)`: width of column config/counter.
- `ROW_W`, 16: width of row config/counter.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: synchronous active-high reset.
- `start` in 1: one-cycle pulse; latches `cfg_cols`/`cfg_rows` and begins a frame.
- `cfg_cols` in COL_W: frame width, legal 3..MAX_COLS.
- `cfg_rows` in ROW_W: frame height, legal >=3.
- `pix_valid` in 1: pixel present on `pix_data`.
- `pix_data` in signed WID_LINE: pixel value, raster order.
- `pix_ready` out 1: feeder accepts a pixel this cycle.
- `win_1`..`win_9` out signed WID_LINE each: window, row-major; `win_1` is top-left (oldest row, oldest column) and `win_9` is bottom-right (newest pixel).
- `win_valid` out 1: window valid; connects to MAC `enable`.
- `busy` out 1: frame in progress.
- `frame_done` out 1: one-cycle pulse after the last pixel is accepted.
- `cfg_err` out 1: one-cycle pulse when `start` carries an illegal config.

## Operation
- States: IDLE, RUN, DONE.
- IDLE -> RUN on `start` with a legal config. Legal means 3 <= `cfg_cols` <= MAX_COLS and `cfg_rows` >= 3. Entering RUN clears `col`/`row` counters.
- `start` with an illegal config: stay in IDLE and pulse `cfg_err` in the next cycle.
- `start` outside IDLE is ignored, with no `cfg_err`.
- `pix_ready` = 1 exactly in RUN. A pixel is accepted when `pix_valid && pix_ready`.
- On each accept at column `c`:
  - Form the new column {`lb2[c]`, `lb1[c]`, `pix_data`}.
  - Write `lb2[c]` <= `lb1[c]` and `lb1[c]` <= `pix_data`.
  - Shift the 3x3 register window left by one column and insert the new column on the right.
- Counters on each accept:
  - `col` increments; at `cfg_cols-1` it wraps to 0 and `row` increments.
- `win_valid` is registered: it is set to 1 for the accept at (`row`>=2, `col`>=2) and is 0 otherwise, including non-accept cycles.
  - Stale columns left over after a row wrap are never exposed, because of the `col`>=2 gate.
  - Windows per frame = (`cfg_rows`-2)*(`cfg_cols`-2).
- Accept of (`cfg_rows`-1, `cfg_cols`-1) -> DONE. DONE -> IDLE unconditionally after one cycle; `frame_done` = 1 during DONE.
- Line-buffer contents are not cleared between frames or on reset. They are never exposed because of the `row`>=2 gate.
- Gaps (`pix_valid`=0) in RUN: no state change, `win_valid`=0, and `win_*` hold (see Configuration).

## Timing
- Reset values: `pix_ready`=0, `win_valid`=0, `busy`=0, `frame_done`=0, `cfg_err`=0, `win_1..9`=0. State IDLE, counters 0.
- Reset mid-frame: next cycle IDLE with all outputs at reset values. The partial frame is discarded.
- Latency: `win_valid`/`win_*` are updated on the same edge that accepts the completing pixel, i.e. visible one cycle after the handshake cycle.
  - End-to-end to MAC `output_mac` = 1 + 3 cycles.
- `busy` = 1 in RUN and DONE.
- The earliest `start` for the next frame is the cycle after DONE (IDLE).
- Line buffers: one read and one write per cycle to the same address. The read returns the old data (read-before-write), so they map to simple dual-port RAM or registers.
- Throughput: one pixel and at most one window per cycle; there is no backpressure from downstream.

## Configuration
- `FEEDER_ZERO_GATE_EN`: defined -> `win_1..9` are driven to 0 in every cycle where `win_valid`=0, mirroring MAC enable gating. Lower toggle activity; safe for MACs without enable.
- Undefined -> `win_1..9` hold their last registered value when `win_valid`=0. Only `win_valid` qualifies data.

## Test plan
- 4x4 frame, pixels 1..16 back-to-back -> exactly 4 windows. First window is {1,2,3,5,6,7,9,10,11}; last is {6,7,8,10,11,12,14,15,16}. `frame_done` pulses one cycle after accepting 16.
- Same frame with `pix_valid` toggled 1010... -> identical 4 windows, `win_valid` never high in gap+1 cycles. Window contents hold (macro off) or read 0 (macro on).
- `start` with `cfg_cols`=2, then with `cfg_cols`=MAX_COLS+1 -> `cfg_err` pulses each time; `busy` stays 0.
- `cfg_cols`=MAX_COLS, `cfg_rows`=3, ramp data -> MAX_COLS-2 windows. The line buffer wrap is correct at the last address.
- `rst` asserted after 7 pixels of a 4x4 frame -> all outputs 0 the next cycle. A new 4x4 frame afterwards yields the same 4 windows as the first scenario.
- `start` pulsed mid-frame -> ignored; the frame completes with the expected window count.

Source files
------------

// File: rtl/conv_window_feeder.sv
// rtl/conv_window_feeder.sv - streaming 3x3 window generator feeding the convolver MACs (option macro: FEEDER_ZERO_GATE_EN)
module conv_window_feeder #(
  parameter int WID_LINE = 16,
  parameter int MAX_COLS = 256,
  parameter int COL_W    = $clog2(MAX_COLS + 1),
  parameter int ROW_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [COL_W-1:0]           cfg_cols,
  input  logic [ROW_W-1:0]           cfg_rows,
  input  logic                       pix_valid,
  input  logic signed [WID_LINE-1:0] pix_data,
  output logic                       pix_ready,
  output logic signed [WID_LINE-1:0] win_1,
  output logic signed [WID_LINE-1:0] win_2,
  output logic signed [WID_LINE-1:0] win_3,
  output logic signed [WID_LINE-1:0] win_4,
  output logic signed [WID_LINE-1:0] win_5,
  output logic signed [WID_LINE-1:0] win_6,
  output logic signed [WID_LINE-1:0] win_7,
  output logic signed [WID_LINE-1:0] win_8,
  output logic signed [WID_LINE-1:0] win_9,
  output logic                       win_valid,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       cfg_err
);

  localparam int AW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
  localparam logic [COL_W-1:0] COLS_MIN = COL_W'(3);
  localparam logic [COL_W-1:0] COLS_MAX = COL_W'(MAX_COLS);
  localparam logic [ROW_W-1:0] ROWS_MIN = ROW_W'(3);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                     state;
  logic [COL_W-1:0]           col;
  logic [COL_W-1:0]           cols_r;
  logic [ROW_W-1:0]           row;
  logic [ROW_W-1:0]           rows_r;
  logic signed [WID_LINE-1:0] lb1 [MAX_COLS];
  logic signed [WID_LINE-1:0] lb2 [MAX_COLS];
  logic signed [WID_LINE-1:0] col_old [3];
  logic signed [WID_LINE-1:0] col_mid [3];
  logic signed [WID_LINE-1:0] col_new [3];
  logic signed [WID_LINE-1:0] win_next [9];
  logic signed [WID_LINE-1:0] win_q [9];
  logic [AW-1:0]              addr;
  logic                       accept;
  logic                       cfg_ok;
  logic                       last_col;
  logic                       last_row;
  logic                       win_pos;

  assign addr     = col[AW-1:0];
  assign accept   = (state == RUN) && pix_valid;
  assign cfg_ok   = (cfg_cols >= COLS_MIN) && (cfg_cols <= COLS_MAX) && (cfg_rows >= ROWS_MIN);
  assign last_col = (col == cols_r - COL_W'(1));
  assign last_row = (row == rows_r - ROW_W'(1));
  assign win_pos  = (row >= ROW_W'(2)) && (col >= COL_W'(2));

  // Incoming column: two buffered rows above plus the live pixel (read-before-write)
  assign col_new[0] = lb2[addr];
  assign col_new[1] = lb1[addr];
  assign col_new[2] = pix_data;

  // Assemble the row-major window from the two held columns and the incoming one
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_next[3*r]     = col_old[r];
      win_next[3*r + 1] = col_mid[r];
      win_next[3*r + 2] = col_new[r];
    end
  end

  // Line buffers: push the column down one row on every accepted pixel, never cleared
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      lb2[addr] <= lb1[addr];
      lb1[addr] <= pix_data;
    end
  end

  // Frame sequencing, column history shift and registered window output
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      cols_r    <= '0;
      rows_r    <= '0;
      cfg_err   <= 1'b0;
      win_valid <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        col_old[i] <= '0;
        col_mid[i] <= '0;
      end
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      cfg_err   <= 1'b0;
      win_valid <= 1'b0;
`ifdef FEEDER_ZERO_GATE_EN
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              state  <= RUN;
              cols_r <= cfg_cols;
              rows_r <= cfg_rows;
              col    <= '0;
              row    <= '0;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (pix_valid) begin
            for (int i = 0; i < 3; i++) begin
              col_old[i] <= col_mid[i];
              col_mid[i] <= col_new[i];
            end
            if (win_pos) begin
              win_valid <= 1'b1;
              for (int i = 0; i < 9; i++) win_q[i] <= win_next[i];
            end
            if (last_col) begin
              col <= '0;
              row <= row + ROW_W'(1);
              if (last_row) state <= DONE;
            end else begin
              col <= col + COL_W'(1);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign pix_ready  = (state == RUN);
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

  assign win_1 = win_q[0];
  assign win_2 = win_q[1];
  assign win_3 = win_q[2];
  assign win_4 = win_q[3];
  assign win_5 = win_q[4];
  assign win_6 = win_q[5];
  assign win_7 = win_q[6];
  assign win_8 = win_q[7];
  assign win_9 = win_q[8];

endmodule

// File: tb/tb_conv_window_feeder.sv
// tb/tb_conv_window_feeder.sv - self-checking bench for conv_window_feeder
module tb_conv_window_feeder;

  localparam int WID   = 16;
  localparam int MAXC  = 256;
  localparam int COL_W = $clog2(MAXC + 1);
  localparam int ROW_W = 16;

  typedef int win_t [9];

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic [COL_W-1:0]      cfg_cols = '0;
  logic [ROW_W-1:0]      cfg_rows = '0;
  logic                  pix_valid = 1'b0;
  logic signed [WID-1:0] pix_data = '0;
  logic                  pix_ready;
  logic signed [WID-1:0] win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8, win_9;
  logic                  win_valid, busy, frame_done, cfg_err;

  conv_window_feeder #(.WID_LINE(WID), .MAX_COLS(MAXC), .COL_W(COL_W), .ROW_W(ROW_W)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .win_1(win_1), .win_2(win_2), .win_3(win_3), .win_4(win_4), .win_5(win_5),
    .win_6(win_6), .win_7(win_7), .win_8(win_8), .win_9(win_9),
    .win_valid(win_valid), .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  task automatic chk(string nm, logic signed [31:0] act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: frame kept as a flat raster image; windows cut straight out of it
  int  img [0:1023];
  bit  m_run = 1'b0, m_done = 1'b0, exp_valid = 1'b0, exp_err = 1'b0;
  int  m_cnt = 0, m_cols = 0, m_rows = 0;
  int  exp_win [9];
  int  mod_nwin = 0;
  int  modw [$];
  int  dut_nwin = 0;
  int  dutw [$];

  always @(posedge clk) begin
    int r, c;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (rst) begin
      m_run  = 1'b0;
      m_done = 1'b0;
      for (int k = 0; k < 9; k++) exp_win[k] = 0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (!m_run) begin
      if (start) begin
        if (cfg_cols >= 3 && cfg_cols <= MAXC && cfg_rows >= 3) begin
          m_run  = 1'b1;
          m_cnt  = 0;
          m_cols = int'(cfg_cols);
          m_rows = int'(cfg_rows);
        end else begin
          exp_err = 1'b1;
        end
      end
    end else if (pix_valid) begin
      img[m_cnt] = pix_data;
      r = m_cnt / m_cols;
      c = m_cnt % m_cols;
      if (r >= 2 && c >= 2) begin
        exp_valid = 1'b1;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            exp_win[3*i + j] = img[(r - 2 + i) * m_cols + (c - 2 + j)];
        for (int k = 0; k < 9; k++) modw.push_back(exp_win[k]);
        mod_nwin++;
      end
      m_cnt++;
      if (m_cnt == m_rows * m_cols) begin
        m_run  = 1'b0;
        m_done = 1'b1;
      end
    end
`ifdef FEEDER_ZERO_GATE_EN
    if (!exp_valid) for (int k = 0; k < 9; k++) exp_win[k] = 0;
`endif
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (checking) begin
      chk("pix_ready", pix_ready, int'(m_run));
      chk("busy", busy, int'(m_run || m_done));
      chk("frame_done", frame_done, int'(m_done));
      chk("cfg_err", cfg_err, int'(exp_err));
      chk("win_valid", win_valid, int'(exp_valid));
      chk("win_1", win_1, exp_win[0]);
      chk("win_2", win_2, exp_win[1]);
      chk("win_3", win_3, exp_win[2]);
      chk("win_4", win_4, exp_win[3]);
      chk("win_5", win_5, exp_win[4]);
      chk("win_6", win_6, exp_win[5]);
      chk("win_7", win_7, exp_win[6]);
      chk("win_8", win_8, exp_win[7]);
      chk("win_9", win_9, exp_win[8]);
      if (win_valid === 1'b1) begin
        dutw.push_back(win_1); dutw.push_back(win_2); dutw.push_back(win_3);
        dutw.push_back(win_4); dutw.push_back(win_5); dutw.push_back(win_6);
        dutw.push_back(win_7); dutw.push_back(win_8); dutw.push_back(win_9);
        dut_nwin++;
      end
    end
  end

  task automatic check_win(string nm, bit from_dut, int idx, win_t e);
    int sz;
    sz = from_dut ? dutw.size() : modw.size();
    if ((idx + 1) * 9 > sz) begin
      checks++;
      errors++;
      $display("FAIL %s: window %0d missing, only %0d recorded", nm, idx, sz / 9);
    end else begin
      for (int k = 0; k < 9; k++)
        chk($sformatf("%s[%0d]", nm, k), from_dut ? dutw[idx*9 + k] : modw[idx*9 + k], e[k]);
    end
  endtask

  task automatic frame_checks(string tag, int n0, int m0, int nexp, win_t first, win_t last);
    chk({tag, "_dut_count"}, dut_nwin - n0, nexp);
    chk({tag, "_model_count"}, mod_nwin - m0, nexp);
    check_win({tag, "_dut_first"}, 1'b1, n0, first);
    check_win({tag, "_dut_last"}, 1'b1, n0 + nexp - 1, last);
    check_win({tag, "_model_first"}, 1'b0, m0, first);
    check_win({tag, "_model_last"}, 1'b0, m0 + nexp - 1, last);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(int c, int r);
    start    = 1'b1;
    cfg_cols = COL_W'(c);
    cfg_rows = ROW_W'(r);
    tick();
    start = 1'b0;
  endtask

  task automatic send(int v);
    pix_valid = 1'b1;
    pix_data  = WID'(v);
    tick();
    pix_valid = 1'b0;
  endtask

  win_t w44_first = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
  win_t w44_last  = '{6, 7, 8, 10, 11, 12, 14, 15, 16};
  win_t wide_first = '{1, 2, 3, 257, 258, 259, 513, 514, 515};
  win_t wide_last  = '{254, 255, 256, 510, 511, 512, 766, 767, 768};
  int n0, m0;

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    checking = 1'b1;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_pix_ready", pix_ready, 0);
    chk("reset_win_valid", win_valid, 0);
    chk("reset_win_5", win_5, 0);
    tick();

    // 4x4 back-to-back
    n0 = dut_nwin; m0 = mod_nwin;
    start_frame(4, 4);
    for (int i = 1; i <= 16; i++) send(i);
    @(negedge clk);
    chk("s1_frame_done", frame_done, 1);
    repeat (3) tick();
    frame_checks("s1", n0, m0, 4, w44_first, w44_last);

    // 4x4 with a gap after every pixel
    n0 = dut_nwin; m0 = mod_nwin;
    start_frame(4, 4);
    for (int i = 1; i <= 16; i++) begin
      send(i);
      tick();
    end
    repeat (3) tick();
    frame_checks("s2", n0, m0, 4, w44_first, w44_last);

    // illegal configurations
    start_frame(2, 4);
    @(negedge clk);
    chk("s3_cfg_err_narrow", cfg_err, 1);
    chk("s3_busy_narrow", busy, 0);
    start_frame(MAXC + 1, 4);
    @(negedge clk);
    chk("s3_cfg_err_wide", cfg_err, 1);
    chk("s3_busy_wide", busy, 0);
    tick();

    // full-width frame, three rows
    n0 = dut_nwin; m0 = mod_nwin;
    start_frame(MAXC, 3);
    for (int i = 1; i <= MAXC * 3; i++) send(i);
    repeat (3) tick();
    frame_checks("s4", n0, m0, MAXC - 2, wide_first, wide_last);

    // reset mid-frame, then a clean frame
    start_frame(4, 4);
    for (int i = 1; i <= 7; i++) send(100 + i);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("s5_busy", busy, 0);
    chk("s5_pix_ready", pix_ready, 0);
    chk("s5_win_valid", win_valid, 0);
    chk("s5_frame_done", frame_done, 0);
    chk("s5_win_1", win_1, 0);
    chk("s5_win_9", win_9, 0);
    tick();
    n0 = dut_nwin; m0 = mod_nwin;
    start_frame(4, 4);
    for (int i = 1; i <= 16; i++) send(i);
    repeat (3) tick();
    frame_checks("s5", n0, m0, 4, w44_first, w44_last);

    // start pulse in the middle of a frame is ignored
    n0 = dut_nwin; m0 = mod_nwin;
    start_frame(4, 4);
    for (int i = 1; i <= 5; i++) send(i);
    start    = 1'b1;
    cfg_cols = COL_W'(5);
    send(6);
    start = 1'b0;
    for (int i = 7; i <= 16; i++) send(i);
    repeat (3) tick();
    frame_checks("s6", n0, m0, 4, w44_first, w44_last);

    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
